// File: rtl/i3c_timec_pkg.sv
// Shared types and constants for the multistage IBI timing-control counter.
package i3c_timec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timec_state_e;

    // First selector value that maps onto capture byte 0.
    localparam int TIMEC_SEL_BASE = 5;

    // Bytes in the packed capture image: stage 0 is W0 wide, later stages WN wide.
    function automatic int timec_total_bytes(input int nstage, input int w0, input int wn);
        return (w0 / 8) + ((nstage - 1) * (wn / 8));
    endfunction

endpackage

// File: rtl/i3c_timec_edge_sync.sv
// Three-flop synchroniser for an asynchronous level, with a one-cycle
// rising-edge pulse taken between the second and third stages.
module i3c_timec_edge_sync (
    input  logic CLK_SLOW,
    input  logic RSTn,
    input  logic din,
    output logic pulse
);

    logic [2:0] s_q;
    logic [2:0] s_d;

    // Shift the incoming level one stage per slow clock.
    always_comb begin
        s_d = {s_q[1:0], din};
    end

    // Synchroniser flops.
    always_ff @(posedge CLK_SLOW or negedge RSTn) begin
        if (!RSTn) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign pulse = s_q[1] & ~s_q[2];

endmodule

// File: rtl/i3c_timec_multistage.sv
// Multistage IBI timestamp counter: measures event start -> stop[0] and
// stop[k-1] -> stop[k] in CLK_SLOW cycles and exposes the captures byte-wise.
// Optional build macro I3C_TIMEC_PRESCALE_EN adds a prescale[3:0] input that
// slows the counters down by (prescale+1).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start pulse, captures/valid held
// RUN     | counting stage stage_q, waiting for stop_p[stage_q]
// DONE    | captures valid, a new start pulse restarts the measurement
module i3c_timec_multistage
    import i3c_timec_pkg::*;
#(
    parameter int NSTAGE = 2,
    parameter int W0     = 16,
    parameter int WN     = 8,
    parameter int SEL_W  = 4
) (
    input  logic              CLK_SLOW,
    input  logic              RSTn,
    input  logic              clk_SCL_n,
    input  logic              scan_no_rst,
    input  logic [2:0]        timec_ena,
    input  logic              event_start,
    input  logic [NSTAGE-1:0] stop,
    input  logic [SEL_W-1:0]  time_info_sel,
`ifdef I3C_TIMEC_PRESCALE_EN
    input  logic [3:0]        prescale,
`endif
    output logic [7:0]        time_info_byte,
    output logic              ibi_timec,
    output logic              time_overflow,
    output logic              busy
);

    localparam int CW          = (W0 > WN) ? W0 : WN;
    localparam int TOTAL_BYTES = timec_total_bytes(NSTAGE, W0, WN);
    localparam int CAP_W       = TOTAL_BYTES * 8;
    localparam logic [CW-1:0] SAT0 = CW'({W0{1'b1}});
    localparam logic [CW-1:0] SATN = CW'({WN{1'b1}});

    logic              ev_scl_q, ev_scl_d;
    logic              start_p;
    logic [NSTAGE-1:0] stop_p;
    timec_state_e      state_q, state_d;
    logic [1:0]        stage_q, stage_d;
    logic [CW-1:0]     cnt_q, cnt_d, sat_val;
    logic [CAP_W-1:0]  cap_q, cap_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              stop_hit, cnt_tick, sel_hit;
    logic              unused_scan;
`ifdef I3C_TIMEC_PRESCALE_EN
    logic [3:0]        div_q, div_d;
`endif

    // Scan control has no functional effect on this block.
    assign unused_scan = scan_no_rst;

    // Stretch event_start by one SCL period so short SCL-domain pulses survive.
    always_comb begin
        ev_scl_d = event_start;
    end

    // SCL-domain capture of the start indication.
    always_ff @(posedge clk_SCL_n or negedge RSTn) begin
        if (!RSTn) begin
            ev_scl_q <= 1'b0;
        end else begin
            ev_scl_q <= ev_scl_d;
        end
    end

    i3c_timec_edge_sync u_start_sync (
        .CLK_SLOW (CLK_SLOW),
        .RSTn     (RSTn),
        .din      (event_start | ev_scl_q),
        .pulse    (start_p)
    );

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stop_sync
        i3c_timec_edge_sync u_stop_sync (
            .CLK_SLOW (CLK_SLOW),
            .RSTn     (RSTn),
            .din      (stop[g]),
            .pulse    (stop_p[g])
        );
    end

    // Measurement FSM next-state: stage advance, saturation and capture.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        valid_d  = valid_q;
        ovf_d    = 1'b0;
        stop_hit = 1'b0;
`ifdef I3C_TIMEC_PRESCALE_EN
        div_d    = div_q;
        cnt_tick = (div_q == prescale);
`else
        cnt_tick = 1'b1;
`endif
        // Only the marker belonging to the current stage counts.
        for (int i = 0; i < NSTAGE; i++) begin
            if (int'(stage_q) == i) stop_hit = stop_p[i];
        end
        sat_val = (stage_q == 2'd0) ? SAT0 : SATN;

        if (timec_ena == 3'd0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_p) begin
                        state_d = ST_RUN;
                        stage_d = 2'd0;
                        cnt_d   = CW'(1);
                        cap_d   = '0;
                        valid_d = 1'b0;
`ifdef I3C_TIMEC_PRESCALE_EN
                        div_d   = '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (stop_hit || (cnt_q == sat_val)) begin
                        // On saturation cnt_q already equals the all-ones value.
                        if (stage_q == 2'd0) cap_d[W0-1:0] = cnt_q[W0-1:0];
                        for (int i = 1; i < NSTAGE; i++) begin
                            if (int'(stage_q) == i) cap_d[W0 + (i-1)*WN +: WN] = cnt_q[WN-1:0];
                        end
                        if (stop_hit && (int'(stage_q) < NSTAGE - 1)) begin
                            stage_d = stage_q + 2'd1;
                            cnt_d   = CW'(1);
`ifdef I3C_TIMEC_PRESCALE_EN
                            div_d   = '0;
`endif
                        end else begin
                            state_d = ST_DONE;
                            valid_d = 1'b1;
                            ovf_d   = ~stop_hit;
                        end
                    end else if (cnt_tick) begin
                        cnt_d = cnt_q + CW'(1);
`ifdef I3C_TIMEC_PRESCALE_EN
                        div_d = '0;
`endif
                    end else begin
`ifdef I3C_TIMEC_PRESCALE_EN
                        div_d = div_q + 4'd1;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // FSM, counter, capture and registered status flops.
    always_ff @(posedge CLK_SLOW or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            stage_q <= 2'd0;
            cnt_q   <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef I3C_TIMEC_PRESCALE_EN
            div_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
`ifdef I3C_TIMEC_PRESCALE_EN
            div_q   <= div_d;
`endif
        end
    end

    // Byte readout: the capture vector is already packed little-endian.
    always_comb begin
        time_info_byte = 8'h00;
        sel_hit        = 1'b0;
        for (int b = 0; b < TOTAL_BYTES; b++) begin
            if (int'(time_info_sel) == TIMEC_SEL_BASE + b) begin
                time_info_byte = cap_q[b*8 +: 8];
                sel_hit        = 1'b1;
            end
        end
    end

    assign ibi_timec     = valid_q & (timec_ena != 3'd0) & sel_hit;
    assign time_overflow = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_i3c_timec_multistage.sv
// Randomised self-checking bench for i3c_timec_multistage (NSTAGE=2, W0=16, WN=8).
module tb_i3c_timec_multistage;

    localparam int NSTAGE = 2;
    localparam int W0     = 16;
    localparam int WN     = 8;
    localparam int SEL_W  = 4;

    logic              CLK_SLOW    = 1'b0;
    logic              RSTn        = 1'b0;
    logic              clk_SCL_n   = 1'b0;
    logic              scan_no_rst = 1'b0;
    logic [2:0]        timec_ena;
    logic              event_start;
    logic [NSTAGE-1:0] stop;
    logic [SEL_W-1:0]  time_info_sel;
`ifdef I3C_TIMEC_PRESCALE_EN
    logic [3:0]        prescale;
`endif
    logic [7:0]        time_info_byte;
    logic              ibi_timec;
    logic              time_overflow;
    logic              busy;

    int n_cmp    = 0;
    int n_err    = 0;
    int ovf_seen = 0;

    i3c_timec_multistage #(
        .NSTAGE (NSTAGE),
        .W0     (W0),
        .WN     (WN),
        .SEL_W  (SEL_W)
    ) dut (
        .CLK_SLOW       (CLK_SLOW),
        .RSTn           (RSTn),
        .clk_SCL_n      (clk_SCL_n),
        .scan_no_rst    (scan_no_rst),
        .timec_ena      (timec_ena),
        .event_start    (event_start),
        .stop           (stop),
        .time_info_sel  (time_info_sel),
`ifdef I3C_TIMEC_PRESCALE_EN
        .prescale       (prescale),
`endif
        .time_info_byte (time_info_byte),
        .ibi_timec      (ibi_timec),
        .time_overflow  (time_overflow),
        .busy           (busy)
    );

    always #5 CLK_SLOW  = ~CLK_SLOW;
    always #3 clk_SCL_n = ~clk_SCL_n;

    // Count every slow cycle in which the overflow flag is high.
    always @(negedge CLK_SLOW) begin
        if (time_overflow) ovf_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: stop k rising t[k] cycles after the start rising edge.
    // A stage measures the gap to its own marker; a marker that rose no later
    // than the previous one is never seen, so that stage runs to all-ones.
    function automatic void model(input int t0, input int t1,
                                  output int tc0, output int tc1, output int ovf);
        int t[2];
        int tc[2];
        int prev, mx, delta;
        bit ended;
        t[0] = t0; t[1] = t1;
        prev = 0; ended = 0; ovf = 0;
        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? (1 << W0) - 1 : (1 << WN) - 1;
            if (ended) begin
                tc[k] = 0;
            end else begin
                delta = (t[k] < 0) ? mx + 1 : t[k] - prev;
                if (delta <= 0) delta = mx + 1;
                if (delta > mx) begin
                    tc[k] = mx; ovf = 1; ended = 1;
                end else begin
                    tc[k] = delta; prev = t[k];
                end
            end
        end
        tc0 = tc[0]; tc1 = tc[1];
    endfunction

    task automatic run_event(input int t0, input int t1, input string tag);
        int tc0, tc1, ovf, ovf0, tmax, waited, idx;
        int eb[3];
        model(t0, t1, tc0, tc1, ovf);
        eb[0] = tc0 & 8'hFF; eb[1] = (tc0 >> 8) & 8'hFF; eb[2] = tc1 & 8'hFF;
        @(posedge CLK_SLOW); #1;
        ovf0 = ovf_seen;
        event_start = 1'b1;
        tmax = (t1 > t0) ? t1 : t0;
        for (int c = 1; c <= tmax; c++) begin
            @(posedge CLK_SLOW); #1;
            if (c == 3) chk({tag, "_busy_hi"}, busy, 1);
            event_start = (c < 3);
            if (c == t0) stop[0] = 1'b1;
            if (c == t1) stop[1] = 1'b1;
        end
        waited = 0;
        while (busy && waited < 70000) begin
            @(posedge CLK_SLOW); #1;
            waited++;
        end
        chk({tag, "_busy_fall"}, busy, 0);
        repeat (2) @(posedge CLK_SLOW);
        #1;
        chk({tag, "_ovf_cycles"}, ovf_seen - ovf0, ovf);
        for (int s = 0; s < 16; s++) begin
            time_info_sel = 4'(s);
            @(negedge CLK_SLOW);
            idx = s - 5;
            chk($sformatf("%s_byte_sel%0d", tag, s), time_info_byte,
                (idx >= 0 && idx < 3) ? eb[idx] : 0);
            chk($sformatf("%s_ibi_sel%0d", tag, s), ibi_timec, (idx >= 0 && idx < 3) ? 1 : 0);
            @(posedge CLK_SLOW); #1;
        end
        event_start = 1'b0;
        stop = '0;
        repeat (5) @(posedge CLK_SLOW);
    endtask

    initial begin
        int t0, t1, mode;
        timec_ena     = 3'd1;
        event_start   = 1'b0;
        stop          = '0;
        time_info_sel = 4'd5;
`ifdef I3C_TIMEC_PRESCALE_EN
        prescale      = 4'd0;
`endif
        repeat (3) @(posedge CLK_SLOW);
        @(negedge CLK_SLOW);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", time_overflow, 0);
        chk("rst_ibi", ibi_timec, 0);
        chk("rst_byte", time_info_byte, 0);
        @(posedge CLK_SLOW); #1;
        RSTn = 1'b1;
        repeat (3) @(posedge CLK_SLOW);

        run_event(300, 340, "basic");
        run_event(10, -1, "ovf_stage1");
        run_event(30, 20, "out_of_order");
        run_event(65535, 65555, "simul_sat");

        for (int n = 0; n < 12; n++) begin
            t0   = int'($urandom_range(5, 400));
            mode = int'($urandom_range(0, 3));
            if (mode == 0)      t1 = -1;
            else if (mode == 1) t1 = t0 - int'($urandom_range(0, 4));
            else                t1 = t0 + int'($urandom_range(1, 300));
            run_event(t0, t1, $sformatf("rand%0d", n));
        end

        // Disable mid-RUN: stage 0 already captured 50, stage 1 in progress.
        @(posedge CLK_SLOW); #1;
        event_start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge CLK_SLOW); #1;
            event_start = (c < 3);
            if (c == 50) stop[0] = 1'b1;
        end
        timec_ena = 3'd0;
        @(posedge CLK_SLOW); #1;
        chk("dis_busy", busy, 0);
        time_info_sel = 4'd5;
        @(negedge CLK_SLOW);
        chk("dis_tc0_lo", time_info_byte, 50);
        chk("dis_ibi", ibi_timec, 0);
        @(posedge CLK_SLOW); #1;
        time_info_sel = 4'd7;
        stop[1] = 1'b1;
        @(negedge CLK_SLOW);
        chk("dis_tc1", time_info_byte, 0);
        repeat (5) @(posedge CLK_SLOW);
        #1;
        timec_ena = 3'd1;
        repeat (5) @(posedge CLK_SLOW);
        #1;
        chk("dis_reena_busy", busy, 0);
        time_info_sel = 4'd5;
        @(negedge CLK_SLOW);
        chk("dis_tc0_kept", time_info_byte, 50);
        stop = '0;
        repeat (5) @(posedge CLK_SLOW);

        // Reset during RUN after stage 0 has captured.
        #1;
        event_start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge CLK_SLOW); #1;
            event_start = (c < 3);
            if (c == 30) stop[0] = 1'b1;
        end
        time_info_sel = 4'd5;
        #2;
        RSTn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", time_overflow, 0);
        chk("mid_rst_ibi", ibi_timec, 0);
        chk("mid_rst_tc0", time_info_byte, 0);
        event_start = 1'b0;
        stop = '0;
        repeat (3) @(posedge CLK_SLOW);
        #1;
        RSTn = 1'b1;
        repeat (3) @(posedge CLK_SLOW);
        run_event(7, 12, "post_rst");

`ifdef I3C_TIMEC_PRESCALE_EN
        begin
            logic [15:0] tc0_ps;
            prescale = 4'd3;
            @(posedge CLK_SLOW); #1;
            event_start = 1'b1;
            for (int c = 1; c <= 401; c++) begin
                @(posedge CLK_SLOW); #1;
                event_start = (c < 3);
                if (c == 400) stop[0] = 1'b1;
                if (c == 401) stop[1] = 1'b1;
            end
            repeat (10) @(posedge CLK_SLOW);
            #1;
            chk("ps_busy_fall", busy, 0);
            time_info_sel = 4'd5;
            @(negedge CLK_SLOW);
            tc0_ps[7:0] = time_info_byte;
            @(posedge CLK_SLOW); #1;
            time_info_sel = 4'd6;
            @(negedge CLK_SLOW);
            tc0_ps[15:8] = time_info_byte;
            chk("ps_tc0_near_100", (tc0_ps >= 16'd99 && tc0_ps <= 16'd101) ? 1 : 0, 1);
            prescale = 4'd0;
            event_start = 1'b0;
            stop = '0;
            repeat (5) @(posedge CLK_SLOW);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i3c_timec_multistage.md
Name: i3c_timec_multistage

Overview:
- Parametrised successor of the I3C IBI timing-control counter block for async timestamp mode.
- Measures the delay from an IBI event start to the first SC stop marker, then between NSTAGE successive stop markers, all in CLK_SLOW cycles.
- Captured counts are exposed byte-wise to the IBI payload mux.
- Sits between the SCL-domain IBI engine and the slave's IBI data path.

Parameters:
- NSTAGE, 2: number of stop markers and capture registers (1..4).
- W0, 16: width of stage-0 counter, event start to stop[0]; multiple of 8.
- WN, 8: width of stage-k counters, stop[k-1] to stop[k], k>=1; multiple of 8.
- SEL_W, 4: width of time_info_sel.

Ports:
- CLK_SLOW  in  1  free-running slow timing clock.
- RSTn  in  1  reset.
- clk_SCL_n  in  1  inverted SCL; used only to register event_start.
- scan_no_rst  in  1  scan control; no functional effect.
- timec_ena  in  3  timing-control mode; 0 = disabled.
- event_start  in  1  IBI start indication, SCL domain.
- stop  in  NSTAGE  async stop markers; bit k = marker k, level rises once per event.
- time_info_sel  in  SEL_W  byte selector.
- time_info_byte  out  8  selected capture byte.
- ibi_timec  out  1  timing info present for the IBI payload.
- time_overflow  out  1  one-cycle overflow pulse.
- busy  out  1  measurement in progress.

Behaviour:
- Reset RSTn, asynchronous, active-low; clock CLK_SLOW. All flops clear on reset, and every output resets to 0.
- Start path:
  - event_start is registered on posedge clk_SCL_n and ORed with event_start.
  - The result passes through a 3-flop CLK_SLOW shift register.
  - start_p = dly[1] & ~dly[2].
- Stop path:
  - Each stop[k] has its own 3-flop synchroniser.
  - stop_p[k] = s[1] & ~s[2].
  - Latency from a stop edge to the pulse is 2 CLK_SLOW edges.
- FSM states: IDLE, RUN (with stage index k, 0..NSTAGE-1), DONE.
  - IDLE: on start_p with timec_ena!=0, go to RUN, k=0, cnt=1, clear all TC and valid.
  - RUN:
    - cnt increments each cycle and saturates at all-ones of the current stage width (W0 when k=0, WN otherwise).
    - On stop_p[k]: TC[k]<=cnt. If k<NSTAGE-1, then k<=k+1 and cnt<=1; otherwise go to DONE.
  - RUN saturation:
    - When cnt reaches all-ones without stop_p[k], TC[k]<=all-ones and time_overflow pulses for 1 cycle.
    - The FSM goes to DONE; later stages keep TC=0.
  - DONE: valid=1. Holds until the next start_p, which behaves as the IDLE start.
- busy=1 exactly in RUN.
- Simultaneous events:
  - stop_p[k] in the same cycle cnt reaches all-ones: capture wins and no overflow pulse is issued.
  - stop_p[j] with j!=k is ignored.
  - start_p during RUN is ignored.
- timec_ena==0 forces IDLE and cnt=0 on the next edge. TC and valid are retained.
- Readout:
  - Bytes are packed little-endian: TC0 bytes first (W0/8 bytes), then TC1..TC[NSTAGE-1] (WN/8 bytes each).
  - byte index = time_info_sel - 5.
  - Selectors below 5 or beyond the packed length return 8'h00.
  - Output is combinational from the capture registers.
- ibi_timec = valid & (timec_ena!=0) & (time_info_sel>=5) & (time_info_sel < 5 + total bytes).

Optional Feature:
- Macro I3C_TIMEC_PRESCALE_EN.
- When defined:
  - Adds input prescale[3:0].
  - cnt advances only when an internal divider reaches prescale; the divider clears on every stage entry.
  - prescale=0 is identical to no prescaler.
- When undefined: no port, no divider, cnt advances every cycle.

Decomposition:
- Package i3c_timec_pkg:
  - FSM state enum.
  - Selector base constant TIMEC_SEL_BASE=5.
  - Function computing total byte count from NSTAGE/W0/WN.
- Sub-module i3c_timec_edge_sync: 3-flop synchroniser plus rising-edge pulse. Instantiated once for start and NSTAGE times for stop.

Test Plan:
- Basic capture, NSTAGE=2, W0=16, WN=8:
  - Stimulus: start, stop[0] 300 cycles later, stop[1] 40 cycles after that.
  - Required: TC0=16'h012C, TC1=8'h28.
  - Required readout: sel=5->2C, 6->01, 7->28, 8->00; ibi_timec=1 for sel 5..7.
- Stage-1 overflow:
  - Stimulus: start, stop[0] after 10 cycles, no stop[1].
  - Required: after 255 further cycles TC1=FF, time_overflow high exactly 1 cycle, busy falls.
- Simultaneous capture and saturation:
  - Stimulus: stop_p[0] lands in the same cycle cnt=16'hFFFF.
  - Required: TC0=FFFF, no overflow pulse, FSM advances to stage 1.
- Disable and ignored inputs:
  - Stimulus: timec_ena dropped to 0 mid-RUN.
  - Required: busy=0 next cycle and previous TC values retained.
  - Stimulus: out-of-order stop[1] before stop[0].
  - Required: stop[1] ignored.
- Reset during RUN:
  - Stimulus: RSTn asserted mid-measurement.
  - Required: all outputs and TC clear immediately. A new start after release measures correctly, e.g. 7 cycles gives TC0=7.
- Prescaler, I3C_TIMEC_PRESCALE_EN defined:
  - Stimulus: prescale=3, stop[0] 400 cycles after start.
  - Required: TC0=100 (±1).
